// File: rtl/div_req_sequencer.sv
// Request FIFO and handshake sequencer feeding a sequential divider; returns quotient/remainder
// on a valid/ready response port and answers divide-by-zero locally without starting the divider.
module div_req_sequencer #(
    parameter int W     = 9,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [W-1:0] req_a,
    input  logic [W-1:0] req_b,
    output logic         div_start,
    output logic [W-1:0] div_a,
    output logic [W-1:0] div_b,
    input  logic [W-1:0] div_q,
    input  logic [W-1:0] div_r,
    input  logic         div_ready,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [W-1:0] rsp_q,
    output logic [W-1:0] rsp_r,
    output logic         rsp_dz
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_ACK,
        ST_WAIT_DONE
    } state_t;

    // Handshakes: a transfer happens on a rising edge where valid & ready are both high;
    // valid never depends on ready, and req_ready depends only on registered FIFO occupancy.

    state_t       r_state;
    logic         r_ack_cnt;
    logic         r_div_start;
    logic [W-1:0] r_div_a;
    logic [W-1:0] r_div_b;
    logic         r_rsp_valid;
    logic [W-1:0] r_rsp_q;
    logic [W-1:0] r_rsp_r;
    logic         r_rsp_dz;

    logic [W-1:0] r_mem_a [DEPTH];
    logic [W-1:0] r_mem_b [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    logic         w_empty;
    logic         w_full;
    logic         w_push;
    logic         w_pop;
    logic         w_slot_free;
    logic [W-1:0] w_head_a;
    logic [W-1:0] w_head_b;

    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == (AW+1)'(DEPTH));
    assign req_ready   = ~w_full;
    assign w_push      = req_valid & ~w_full;
    assign w_slot_free = ~r_rsp_valid | rsp_ready;
    assign w_pop       = (r_state == ST_IDLE) & ~w_empty & w_slot_free & div_ready;
    assign w_head_a    = r_mem_a[r_rd_ptr];
    assign w_head_b    = r_mem_b[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_a[r_wr_ptr] <= req_a;
            r_mem_b[r_wr_ptr] <= req_b;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_ack_cnt   <= 1'b0;
            r_div_start <= 1'b0;
            r_div_a     <= '0;
            r_div_b     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_q     <= '0;
            r_rsp_r     <= '0;
            r_rsp_dz    <= 1'b0;
        end else begin
            // A reload below overrides this clear when both happen in one cycle.
            if (r_rsp_valid & rsp_ready) r_rsp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_div_a <= w_head_a;
                        r_div_b <= w_head_b;
                        if (w_head_b == '0) begin
                            r_rsp_q     <= '1;
                            r_rsp_r     <= w_head_a;
                            r_rsp_dz    <= 1'b1;
                            r_rsp_valid <= 1'b1;
                        end else begin
                            r_div_start <= 1'b1;
                            r_state     <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    r_div_start <= 1'b0;
                    r_ack_cnt   <= 1'b0;
                    r_state     <= ST_WAIT_ACK;
                end
                ST_WAIT_ACK: begin
                    if (!div_ready) begin
                        r_state <= ST_WAIT_DONE;
                    end else if (r_ack_cnt) begin
                        // Divider never went busy: pulse start again.
                        r_div_start <= 1'b1;
                        r_state     <= ST_ISSUE;
                    end else begin
                        r_ack_cnt <= 1'b1;
                    end
                end
                ST_WAIT_DONE: begin
                    if (div_ready) begin
                        r_rsp_q     <= div_q;
                        r_rsp_r     <= div_r;
                        r_rsp_dz    <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign div_start = r_div_start;
    assign div_a     = r_div_a;
    assign div_b     = r_div_b;
    assign rsp_valid = r_rsp_valid;
    assign rsp_q     = r_rsp_q;
    assign rsp_r     = r_rsp_r;
    assign rsp_dz    = r_rsp_dz;

endmodule

// File: tb/tb_div_req_sequencer.sv
// Directed bench for div_req_sequencer with a behavioural sequential divider and an
// expected-result queue checked at every response handshake.
module tb_div_req_sequencer;

    localparam int W       = 9;
    localparam int DEPTH   = 4;
    localparam int DIV_LAT = 3;
    localparam int BUDGET  = 200;

    logic         clk;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic [W-1:0] req_a;
    logic [W-1:0] req_b;
    logic         div_start;
    logic [W-1:0] div_a;
    logic [W-1:0] div_b;
    logic [W-1:0] div_q;
    logic [W-1:0] div_r;
    logic         div_ready;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_q;
    logic [W-1:0] rsp_r;
    logic         rsp_dz;

    div_req_sequencer #(.W(W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .div_start (div_start),
        .div_a     (div_a),
        .div_b     (div_b),
        .div_q     (div_q),
        .div_r     (div_r),
        .div_ready (div_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_q     (rsp_q),
        .rsp_r     (rsp_r),
        .rsp_dz    (rsp_dz)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [2*W:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [2*W:0] pack(input logic dz, input logic [W-1:0] q, input logic [W-1:0] r);
        return {dz, q, r};
    endfunction

    // Behavioural divider: not tied to rst, so a sequencer reset leaves it finishing stale work.
    logic         m_ready = 1'b1;
    logic         m_busy  = 1'b0;
    int           m_cnt   = 0;
    logic [W-1:0] m_q     = '0;
    logic [W-1:0] m_r     = '0;
    assign div_ready = m_ready;
    assign div_q     = m_q;
    assign div_r     = m_r;

    always @(negedge clk) begin
        if (m_busy) begin
            if (m_cnt == 0) begin
                m_ready = 1'b1;
                m_busy  = 1'b0;
            end else begin
                m_cnt = m_cnt - 1;
            end
        end else if (div_start === 1'b1) begin
            m_ready = 1'b0;
            m_busy  = 1'b1;
            m_cnt   = DIV_LAT;
            m_q     = (div_b != 0) ? div_a / div_b : '1;
            m_r     = (div_b != 0) ? div_a % div_b : div_a;
        end
    end

    int start_cnt = 0;
    always @(negedge clk) if (div_start === 1'b1) start_cnt++;

    // Scoreboard on response handshakes
    always @(negedge clk) begin
        if (rst === 1'b0 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
            if (exp_q.size() == 0) check("rsp_unexpected", exp_q.size(), 1);
            else check("rsp", {rsp_dz, rsp_q, rsp_r}, exp_q.pop_front());
        end
    end

    // Driver tasks: callers are positioned just after a rising edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] q, input logic [W-1:0] r, input logic dz);
        int n;
        n = 0;
        req_valid = 1'b1;
        req_a     = a;
        req_b     = b;
        @(negedge clk);
        while (req_ready !== 1'b1 && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        check("push_accept", req_ready, 1);
        exp_q.push_back(pack(dz, q, r));
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < BUDGET) begin
            @(posedge clk);
            n++;
        end
        #1;
        check(tag, exp_q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_div_start"}, div_start, 0);
        check({tag, "_div_a"}, div_a, 0);
        check({tag, "_div_b"}, div_b, 0);
        check({tag, "_rsp_valid"}, rsp_valid, 0);
        check({tag, "_rsp_q"}, rsp_q, 0);
        check({tag, "_rsp_r"}, rsp_r, 0);
        check({tag, "_rsp_dz"}, rsp_dz, 0);
        check({tag, "_req_ready"}, req_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        int n;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;

        // 1: reset state
        step(3);
        check_reset_outputs("reset");
        rst = 1'b0;
        step(2);

        // 2: single divide
        s0 = start_cnt;
        push(9'h041, 9'h002, 9'h020, 9'h001, 1'b0);
        drain("drain_single");
        check("single_starts", start_cnt - s0, 1);
        check("single_div_a", div_a, 9'h041);
        check("single_div_b", div_b, 9'h002);

        // 3: two back-to-back, ordered
        push(9'h041, 9'h002, 9'h020, 9'h001, 1'b0);
        push(9'h081, 9'h003, 9'h02B, 9'h000, 1'b0);
        drain("drain_pair");

        // 4: divide by zero, answered locally
        step(2);
        s0 = start_cnt;
        push(9'h0FF, 9'h000, 9'h1FF, 9'h0FF, 1'b1);
        check("dz_not_yet", rsp_valid, 0);
        step(1);
        check("dz_valid", rsp_valid, 1);
        check("dz_q", rsp_q, 9'h1FF);
        check("dz_r", rsp_r, 9'h0FF);
        check("dz_flag", rsp_dz, 1);
        drain("drain_dz");
        step(5);
        check("dz_no_start", start_cnt - s0, 0);

        // 5: back-pressure fills the FIFO; one divide only until rsp_ready rises
        rsp_ready = 1'b0;
        s0 = start_cnt;
        push(9'h100, 9'h010, 9'h010, 9'h000, 1'b0);
        push(9'h1FF, 9'h00A, 9'h033, 9'h001, 1'b0);
        push(9'h064, 9'h007, 9'h00E, 9'h002, 1'b0);
        push(9'h0C8, 9'h000, 9'h1FF, 9'h0C8, 1'b1);
        push(9'h005, 9'h009, 9'h000, 9'h005, 1'b0);
        step(30);
        check("bp_one_start", start_cnt - s0, 1);
        check("bp_rsp_valid", rsp_valid, 1);
        check("bp_head_q", rsp_q, 9'h010);
        check("bp_full", req_ready, 0);
        req_valid = 1'b1;
        req_a     = 9'h12C;
        req_b     = 9'h00B;
        step(5);
        check("bp_stall", req_ready, 0);
        check("bp_pending", exp_q.size(), 5);
        rsp_ready = 1'b1;
        push(9'h12C, 9'h00B, 9'h01B, 9'h003, 1'b0);
        drain("drain_bp");
        check("bp_all_starts", start_cnt - s0, 5);

        // 6: reset while waiting for the divider to finish
        step(2);
        push(9'h0AA, 9'h005, 9'h022, 9'h000, 1'b0);
        n = 0;
        while (div_ready !== 1'b0 && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        check("rst_div_busy", div_ready, 0);
        step(2);
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        void'(exp_q.pop_back());
        step(2);
        rst = 1'b0;
        n = 0;
        while (div_ready !== 1'b1 && n < BUDGET) begin
            @(posedge clk);
            n++;
        end
        step(3);
        check("stale_ignored", rsp_valid, 0);
        push(9'h03C, 9'h004, 9'h00F, 9'h000, 1'b0);
        drain("drain_after_rst");

        step(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
